// File: rtl/round_key_sequencer.sv
// Round-key reader: captures the 11-key bank from key_generator and streams it
// one key per valid/ready handshake, forward for encryption or reverse for decryption.
module round_key_sequencer #(
  parameter int KEY_W    = 8,
  parameter int NUM_KEYS = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W*NUM_KEYS-1:0] key_bus,
  input  logic                      load,
  input  logic                      start,
  input  logic                      dir,
  input  logic                      abort,
  input  logic                      rk_ready,
  output logic                      rk_valid,
  output logic [KEY_W-1:0]          round_key,
  output logic [3:0]                round_idx,
  output logic                      rk_last,
  output logic                      busy,
  output logic                      done,
  output logic                      keys_loaded,
  output logic                      start_err
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {IDLE, SERVE, FINISH} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             dir_q, dir_nxt;
  logic             last_nxt;
  logic [KEY_W-1:0] bank [NUM_KEYS];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (!load && start && keys_loaded) begin
          state_nxt = SERVE;
          dir_nxt   = dir;
          ptr_nxt   = dir ? LAST_IDX : '0;
        end
      end
      SERVE: begin
        // abort outranks a transfer landing in the same cycle
        if (abort) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else if (rk_ready) begin
          if (rk_last) begin
            state_nxt = FINISH;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = dir_q ? ptr - 1'b1 : ptr + 1'b1;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    last_nxt = (state_nxt == SERVE) && (dir_nxt ? (ptr_nxt == '0) : (ptr_nxt == LAST_IDX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      dir_q       <= 1'b0;
      round_key   <= '0;
      rk_last     <= 1'b0;
      keys_loaded <= 1'b0;
      start_err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) bank[i] <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      dir_q     <= dir_nxt;
      round_key <= (state_nxt == SERVE) ? bank[ptr_nxt] : '0;
      rk_last   <= last_nxt;
      start_err <= (state == IDLE) && start && !load && !keys_loaded;
      if (state == IDLE && load) begin
        keys_loaded <= 1'b1;
        for (int unsigned i = 0; i < NUM_KEYS; i++) bank[i] <= key_bus[i*KEY_W +: KEY_W];
      end
    end
  end

  assign rk_valid  = (state == SERVE);
  assign busy      = (state == SERVE);
  assign done      = (state == FINISH);
  assign round_idx = ptr;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: directed test-plan sequences plus random traffic,
// all checked against a queue-based transaction model.
module tb_round_key_sequencer;

  localparam int KEY_W    = 8;
  localparam int NUM_KEYS = 11;

  logic                      clk = 1'b0;
  logic                      rst, load, start, dir, abort, rk_ready;
  logic [KEY_W*NUM_KEYS-1:0] key_bus;
  logic                      rk_valid, rk_last, busy, done, keys_loaded, start_err;
  logic [KEY_W-1:0]          round_key;
  logic [3:0]                round_idx;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: a bank, a loaded flag, and the queue of indices still to be delivered.
  logic [7:0] m_bank [NUM_KEYS];
  bit         m_loaded, m_stream, m_done, m_err;
  int         m_q [$];

  round_key_sequencer #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .rst(rst), .key_bus(key_bus), .load(load), .start(start), .dir(dir),
    .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid), .round_key(round_key),
    .round_idx(round_idx), .rk_last(rk_last), .busy(busy), .done(done),
    .keys_loaded(keys_loaded), .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [KEY_W*NUM_KEYS-1:0] pattern_bus(input int base);
    logic [KEY_W*NUM_KEYS-1:0] b;
    for (int i = 0; i < NUM_KEYS; i++) b[i*KEY_W +: KEY_W] = 8'(base + i);
    return b;
  endfunction

  function automatic logic [KEY_W*NUM_KEYS-1:0] random_bus();
    logic [KEY_W*NUM_KEYS-1:0] b;
    for (int i = 0; i < NUM_KEYS; i++) b[i*KEY_W +: KEY_W] = 8'($urandom);
    return b;
  endfunction

  function automatic void model_update();
    bit n_done = 0, n_err = 0;
    if (rst) begin
      m_loaded = 0; m_stream = 0; m_done = 0; m_err = 0;
      m_q.delete();
      for (int i = 0; i < NUM_KEYS; i++) m_bank[i] = 8'h00;
      return;
    end
    if (m_stream) begin
      if (abort) begin
        m_stream = 0;
        m_q.delete();
      end else if (rk_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_stream = 0;
          n_done = 1;
        end
      end
    end else if (!m_done) begin
      if (load) begin
        for (int i = 0; i < NUM_KEYS; i++) m_bank[i] = key_bus[i*KEY_W +: KEY_W];
        m_loaded = 1;
      end else if (start) begin
        if (m_loaded) begin
          for (int i = 0; i < NUM_KEYS; i++) m_q.push_back(dir ? NUM_KEYS - 1 - i : i);
          m_stream = 1;
        end else begin
          n_err = 1;
        end
      end
    end
    m_done = n_done;
    m_err  = n_err;
  endfunction

  task automatic check_outputs();
    check_eq("rk_valid",    32'(rk_valid),    32'(m_stream));
    check_eq("busy",        32'(busy),        32'(m_stream));
    check_eq("done",        32'(done),        32'(m_done));
    check_eq("keys_loaded", 32'(keys_loaded), 32'(m_loaded));
    check_eq("start_err",   32'(start_err),   32'(m_err));
    check_eq("round_key",   32'(round_key),   m_stream ? 32'(m_bank[m_q[0]]) : 32'h0);
    check_eq("round_idx",   32'(round_idx),   m_stream ? 32'(m_q[0]) : 32'h0);
    check_eq("rk_last",     32'(rk_last),     32'(m_stream && m_q.size() == 1));
  endtask

  // Drive one cycle of inputs, advance the model, then sample on the falling edge.
  task automatic step(input bit r, input bit ld, input bit st, input bit d, input bit ab,
                      input bit rdy, input logic [KEY_W*NUM_KEYS-1:0] kb);
    rst = r; load = ld; start = st; dir = d; abort = ab; rk_ready = rdy; key_bus = kb;
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 1, random_bus());
  endtask

  initial begin
    logic [KEY_W*NUM_KEYS-1:0] kb10, kbff;
    int seen_fwd;
    kb10 = pattern_bus(8'h10);
    kbff = '1;

    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, 1, kb10);            // start with empty bank
    idle_step();
    check_eq("no_stream_after_err", 32'(busy), 32'h0);
    step(0, 1, 1, 0, 0, 1, kb10);            // load wins over start
    idle_step();

    // Forward stream, ready held high; also confirm the fixed key sequence directly
    step(0, 0, 1, 0, 0, 1, kbff);
    seen_fwd = 0;
    for (int i = 0; i < 12; i++) begin
      if (rk_valid) begin
        check_eq("fwd_key_seq", 32'(round_key), 32'(8'h10 + seen_fwd));
        seen_fwd++;
      end
      step(0, 0, 0, 0, 0, 1, kbff);
    end
    check_eq("fwd_key_count", 32'(seen_fwd), 32'd11);

    // Reverse stream
    step(0, 0, 1, 1, 0, 1, kbff);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1, kbff);

    // Backpressure 1,0,0 pattern
    step(0, 0, 1, 0, 0, 1, kbff);
    for (int i = 0; i < 36; i++) step(0, 0, 0, 0, 0, (i % 3) == 0, kbff);

    // Abort after the 4th transfer, then reverse restart with load asserted mid-stream
    step(0, 0, 1, 0, 0, 1, kbff);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, kbff);
    step(0, 0, 0, 0, 1, 1, kbff);
    idle_step();
    step(0, 0, 1, 1, 0, 1, kbff);
    for (int i = 0; i < 12; i++) step(0, i < 6, 0, 0, 0, 1, kbff);

    // Reset mid-stream at idx 5, then start rejected
    step(0, 0, 1, 0, 0, 1, kbff);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, kbff);
    step(1, 0, 0, 0, 0, 1, kbff);
    step(0, 0, 1, 0, 0, 1, kbff);
    idle_step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7),
           random_bus());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
